// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Access latched at grant time; drives the memory for the whole access.
  typedef struct packed {
    owner_e              owner;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF-port, MEM-port and unified-memory signals around the arbiter.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  logic              if_stall_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;
  logic              dm_stall_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o, if_stall_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_ack_o, dm_stall_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o, if_stall_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_ack_o, dm_stall_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/mem_port_arbiter_wait_cnt.sv
// Loadable saturating down-counter; used for wait states and, optionally, fairness.
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory between IF fetches and MEM loads/stores.
// Optional IF anti-starvation: define MEM_ARB_FAIR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned FAIR_LIM = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus
);

  if (WAIT_CYC < 1 || WAIT_CYC > 15 || FAIR_LIM < 1 || FAIR_LIM > 15) begin : g_param_chk
    $error("mem_port_arbiter: WAIT_CYC and FAIR_LIM must lie in 1..15");
  end

  arb_state_e        state_q, state_d;
  mem_req_t          req_q, req_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm, wait_load, wait_dec, wait_zero, force_if;

  mem_arb_wait_cnt u_wait_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (wait_load),
    .load_val_i (CNT_W'(WAIT_CYC - 1)),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

`ifdef MEM_ARB_FAIR_EN
  // Counter holds DM grants still allowed while a fetch waits; zero forces IF.
  logic fair_zero, fair_load, fair_dec;

  assign force_if  = fair_zero & bus.if_req_i;
  assign fair_load = wait_load & (~grant_dm | ~bus.if_req_i);
  assign fair_dec  = wait_load & grant_dm & bus.if_req_i;

  mem_arb_wait_cnt #(.RST_VAL(CNT_W'(FAIR_LIM))) u_fair_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (fair_load),
    .load_val_i (CNT_W'(FAIR_LIM)),
    .dec_i      (fair_dec),
    .zero_o     (fair_zero)
  );
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_dm   = 1'b0;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.dm_req_i || bus.if_req_i) begin
          grant_dm    = bus.dm_req_i & ~force_if;
          wait_load   = 1'b1;
          state_d     = ST_BUSY;
          req_d.owner = grant_dm ? OWN_DM : OWN_IF;
          req_d.we    = grant_dm & bus.dm_we_i;
          req_d.addr  = grant_dm ? bus.dm_addr_i : bus.if_addr_i;
          req_d.wdata = grant_dm ? bus.dm_wdata_i : '0;
        end
      end
      ST_BUSY: begin
        if (wait_zero) begin
          state_d = ST_RESP;
          if (req_q.owner == OWN_IF) if_rdata_d = bus.mem_rdata_i;
          else if (!req_q.we)        dm_rdata_d = bus.mem_rdata_i;
        end else begin
          wait_dec = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Memory strobes and acks follow the next state so they come out registered.
    mem_en_d = (state_d == ST_BUSY);
    mem_we_d = mem_en_d & req_d.we;
    if_ack_d = (state_d == ST_RESP) & (req_d.owner == OWN_IF);
    dm_ack_d = (state_d == ST_RESP) & (req_d.owner == OWN_DM);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = req_q.addr;
  assign bus.mem_wdata_o = req_q.wdata;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_stall_o  = bus.if_req_i & ~if_ack_q;
  assign bus.dm_stall_o  = bus.dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against an access-schedule reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned WAIT_CYC = 2;
  localparam int unsigned FAIR_LIM = 2;
  localparam int          NCYC     = 3000;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.WAIT_CYC(WAIT_CYC), .FAIR_LIM(FAIR_LIM)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Requester state (what the stage logic is holding)
  bit          if_pend, dm_pend, dm_w;
  logic [31:0] if_a, dm_a, dm_wd, mrd;

  // Reference model: one access occupies cycles g+1..g+W, ack at g+W+1
  bit          act, own_dm, m_we;
  int          g, next_free, fair_run;
  logic [31:0] m_addr, m_wdata, cap, e_if_rdata, e_dm_rdata;

  initial begin
    bit rst_c, take_dm, e_en, e_we, e_ifack, e_dmack;
    int rst_left, p_if, p_dm;

    rst_i = 1'b1;
    if_pend = 0; dm_pend = 0; dm_w = 0;
    if_a = '0; dm_a = '0; dm_wd = '0;
    act = 0; own_dm = 0; m_we = 0; g = 0; next_free = 0; fair_run = 0;
    m_addr = '0; m_wdata = '0; cap = '0; e_if_rdata = '0; e_dm_rdata = '0;
    rst_left = 0;
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    bus.mem_rdata_i = '0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk_i);

      if (cyc < 2) rst_c = 1;
      else if (rst_left > 0) begin rst_c = 1; rst_left--; end
      else if ($urandom_range(0, 79) == 0) begin rst_c = 1; rst_left = $urandom_range(0, 1); end
      else rst_c = 0;

      // Traffic phases: mixed, both saturated, IF-heavy
      case ((cyc / 300) % 3)
        0:       begin p_if = 40; p_dm = 40; end
        1:       begin p_if = 100; p_dm = 100; end
        default: begin p_if = 80; p_dm = 15; end
      endcase
      if (!if_pend && $urandom_range(0, 99) < p_if) begin
        if_pend = 1; if_a = $urandom;
      end
      if (!dm_pend && $urandom_range(0, 99) < p_dm) begin
        dm_pend = 1; dm_a = $urandom; dm_w = ($urandom_range(0, 2) == 0); dm_wd = $urandom;
      end
      mrd = $urandom;

      rst_i           = rst_c;
      bus.if_req_i    = if_pend;
      bus.if_addr_i   = if_a;
      bus.dm_req_i    = dm_pend;
      bus.dm_we_i     = dm_w;
      bus.dm_addr_i   = dm_a;
      bus.dm_wdata_i  = dm_wd;
      bus.mem_rdata_i = mrd;

      e_en = 0; e_we = 0; e_ifack = 0; e_dmack = 0;
      if (rst_c) begin
        act = 0; next_free = cyc + 1; fair_run = 0;
        e_if_rdata = '0; e_dm_rdata = '0; m_addr = '0; m_wdata = '0;
      end else begin
        if (act && cyc >= g + 1 && cyc <= g + int'(WAIT_CYC)) begin e_en = 1; e_we = m_we; end
        if (act && cyc == g + int'(WAIT_CYC)) cap = mrd;
        if (act && cyc == g + int'(WAIT_CYC) + 1) begin
          if (own_dm) begin
            e_dmack = 1;
            if (!m_we) e_dm_rdata = cap;
          end else begin
            e_ifack = 1;
            e_if_rdata = cap;
          end
          act = 0;
        end
        if (cyc >= next_free && (if_pend || dm_pend)) begin
          take_dm = dm_pend;
`ifdef MEM_ARB_FAIR_EN
          if (dm_pend && if_pend && fair_run >= int'(FAIR_LIM)) take_dm = 0;
`endif
          fair_run  = (take_dm && if_pend) ? fair_run + 1 : 0;
          act       = 1;
          g         = cyc;
          next_free = cyc + int'(WAIT_CYC) + 2;
          own_dm    = take_dm;
          m_we      = take_dm && dm_w;
          m_addr    = take_dm ? dm_a : if_a;
          m_wdata   = dm_wd;
        end
      end

      #1;
      chk("mem_en",   32'(bus.mem_en_o),   32'(e_en));
      chk("mem_we",   32'(bus.mem_we_o),   32'(e_we));
      chk("if_ack",   32'(bus.if_ack_o),   32'(e_ifack));
      chk("dm_ack",   32'(bus.dm_ack_o),   32'(e_dmack));
      chk("if_stall", 32'(bus.if_stall_o), 32'(if_pend && !e_ifack));
      chk("dm_stall", 32'(bus.dm_stall_o), 32'(dm_pend && !e_dmack));
      chk("if_rdata", bus.if_rdata_o, e_if_rdata);
      chk("dm_rdata", bus.dm_rdata_o, e_dm_rdata);
      if (e_en) chk("mem_addr", bus.mem_addr_o, m_addr);
      if (e_we) chk("mem_wdata", bus.mem_wdata_o, m_wdata);
      if (rst_c) begin
        chk("rst_addr",  bus.mem_addr_o,  32'h0);
        chk("rst_wdata", bus.mem_wdata_o, 32'h0);
      end

      if (e_ifack) if_pend = 0;
      if (e_dmack) dm_pend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
